// File: rtl/mult_err_sweep.sv
// Exhaustive 8x8 sweep that measures error statistics of an approximate multiplier.
// Define REG_IN_EN when the multiplier under test is registered (one-cycle latency).
module mult_err_sweep (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [7:0]  A,
   output logic [7:0]  B,
   input  logic [15:0] R,
   output logic        busy,
   output logic        done,
   output logic [16:0] err_cnt,
   output logic [31:0] err_sum,
   output logic [15:0] max_ed,
   output logic [7:0]  max_a,
   output logic [7:0]  max_b
);

   typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

   state_t      state_q, state_d;
   logic [15:0] k_q, k_d;
   logic [7:0]  a_q, a_d, b_q, b_d;
   logic        busy_q, busy_d, done_q, done_d;
   logic [16:0] cnt_q, cnt_d;
   logic [31:0] sum_q, sum_d;
   logic [15:0] med_q, med_d;
   logic [7:0]  ma_q, ma_d, mb_q, mb_d;

   logic [7:0]  cmp_a, cmp_b;
   logic        cmp_valid;
   logic [15:0] exact, ed;

`ifdef REG_IN_EN
   logic [7:0] da_q, da_d, db_q, db_d;
   logic       dv_q, dv_d;

   // R lags the driven operands by one cycle, so compare against the delayed copy.
   always_comb begin
      da_d      = a_q;
      db_d      = b_q;
      dv_d      = (state_q == SWEEP);
      cmp_a     = da_q;
      cmp_b     = db_q;
      cmp_valid = dv_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         da_q <= '0;
         db_q <= '0;
         dv_q <= 1'b0;
      end else begin
         da_q <= da_d;
         db_q <= db_d;
         dv_q <= dv_d;
      end
   end
`else
   always_comb begin
      cmp_a     = a_q;
      cmp_b     = b_q;
      cmp_valid = (state_q == SWEEP);
   end
`endif

   always_comb begin
      exact = {8'b0, cmp_a} * {8'b0, cmp_b};
      ed    = (exact >= R) ? (exact - R) : (R - exact);
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      med_d   = med_q;
      ma_d    = ma_q;
      mb_d    = mb_q;

      if (cmp_valid) begin
         sum_d = sum_q + {16'b0, ed};
         if (ed != 16'd0) cnt_d = cnt_q + 17'd1;
         if (ed > med_q) begin
            med_d = ed;
            ma_d  = cmp_a;
            mb_d  = cmp_b;
         end
      end

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = SWEEP;
               k_d     = '0;
               cnt_d   = '0;
               sum_d   = '0;
               med_d   = '0;
               ma_d    = '0;
               mb_d    = '0;
            end
         end
         SWEEP: begin
            k_d = k_q + 16'd1;
            if (k_q == 16'hFFFF) begin
`ifdef REG_IN_EN
               state_d = DRAIN;
`else
               state_d = DONE;
`endif
            end
         end
         DRAIN:   state_d = DONE;
         default: state_d = IDLE;
      endcase

      a_d    = (state_d == SWEEP) ? k_d[7:0]  : '0;
      b_d    = (state_d == SWEEP) ? k_d[15:8] : '0;
      busy_d = (state_d == SWEEP) || (state_d == DRAIN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         med_q   <= '0;
         ma_q    <= '0;
         mb_q    <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         a_q     <= a_d;
         b_q     <= b_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         med_q   <= med_d;
         ma_q    <= ma_d;
         mb_q    <= mb_d;
      end
   end

   assign A       = a_q;
   assign B       = b_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign err_cnt = cnt_q;
   assign err_sum = sum_q;
   assign max_ed  = med_q;
   assign max_a   = ma_q;
   assign max_b   = mb_q;

endmodule

// File: tb/tb_mult_err_sweep.sv
// Bench for mult_err_sweep: behavioural multiplier models plus a loop-based statistics model.
// Build with REG_IN_EN defined to exercise the registered-multiplier variant.
module tb_mult_err_sweep;

`ifdef REG_IN_EN
   localparam int unsigned L = 1;
`else
   localparam int unsigned L = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n, start;
   logic [7:0]  A, B;
   logic [15:0] R, r_comb;
   logic        busy, done;
   logic [16:0] err_cnt;
   logic [31:0] err_sum;
   logic [15:0] max_ed;
   logic [7:0]  max_a, max_b;

   int unsigned mode;
   logic [31:0] seed;
   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned c;

   always #5 clk = ~clk;

   mult_err_sweep dut (
      .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .R(R),
      .busy(busy), .done(done), .err_cnt(err_cnt), .err_sum(err_sum),
      .max_ed(max_ed), .max_a(max_a), .max_b(max_b)
   );

   // Multiplier under test: 0 exact, 1 off-by-one at 255x255, 2 stuck at zero, 3 pseudo-random errors
   function automatic logic [15:0] r_of(input logic [7:0] a, input logic [7:0] b,
                                        input int unsigned m, input logic [31:0] s);
      logic [15:0] ex;
      logic [31:0] x;
      ex = {8'b0, a} * {8'b0, b};
      x  = ({16'b0, a, b} * 32'h9E3779B1) ^ s;
      x  = x ^ (x >> 15);
      case (m)
         0:       r_of = ex;
         1:       r_of = (a == 8'd255 && b == 8'd255) ? ex - 16'd1 : ex;
         2:       r_of = 16'd0;
         default: r_of = (x[3:0] == 4'd0) ? x[31:16] : ex;
      endcase
   endfunction

   always_comb r_comb = r_of(A, B, mode, seed);
`ifdef REG_IN_EN
   always_ff @(posedge clk) R <= r_comb;
`else
   assign R = r_comb;
`endif

   task automatic tick(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Statistics over the first n pairs in issue order (A fastest, B slowest).
   task automatic check_stats(input string tag, input int unsigned n);
      int unsigned cnt, sum, med, ma, mb, ex, r, e;
      cnt = 0; sum = 0; med = 0; ma = 0; mb = 0;
      for (int unsigned i = 0; i < n; i++) begin
         ex = (i % 256) * (i / 256);
         r  = r_of(8'(i % 256), 8'(i / 256), mode, seed);
         e  = (ex > r) ? ex - r : r - ex;
         sum += e;
         if (e != 0) cnt++;
         if (e > med) begin
            med = e; ma = i % 256; mb = i / 256;
         end
      end
      chk({tag, ".err_cnt"}, 32'(err_cnt), cnt);
      chk({tag, ".err_sum"}, err_sum, sum);
      chk({tag, ".max_ed"}, 32'(max_ed), med);
      chk({tag, ".max_a"}, 32'(max_a), ma);
      chk({tag, ".max_b"}, 32'(max_b), mb);
   endtask

   task automatic check_idle_zero(input string tag);
      chk({tag, ".busy"}, 32'(busy), 0);
      chk({tag, ".done"}, 32'(done), 0);
      chk({tag, ".A"}, 32'(A), 0);
      chk({tag, ".B"}, 32'(B), 0);
      chk({tag, ".err_cnt"}, 32'(err_cnt), 0);
      chk({tag, ".err_sum"}, err_sum, 0);
      chk({tag, ".max_ed"}, 32'(max_ed), 0);
      chk({tag, ".max_a"}, 32'(max_a), 0);
      chk({tag, ".max_b"}, 32'(max_b), 0);
   endtask

   task automatic start_pulse();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      mode  = 0;
      seed  = $urandom;
      tick(2);
      check_idle_zero("reset");
      rst_n = 1'b1;
      tick(1);

      // Sweep with R stuck at zero, interrupted by reset at k=1000
      mode = 2;
      start_pulse();
      chk("s1_busy", 32'(busy), 1);
      chk("s1_done", 32'(done), 0);
      chk("s1_A0", 32'(A), 0);
      tick(1000);
      chk("s1_A", 32'(A), 1000 % 256);
      chk("s1_B", 32'(B), 1000 / 256);
      check_stats("s1_partial", 1000 - L);
      rst_n = 1'b0;
      #1;
      check_idle_zero("midreset");
      tick(1);
      rst_n = 1'b1;
      tick(1);
      check_idle_zero("postreset");

      // Full sweep with a pseudo-random error model; extra starts at k=500 and at completion
      mode = 3;
      start_pulse();
      c = 0;
      tick(500);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      c = 501;
      chk("s2_busy", 32'(busy), 1);
      chk("s2_A", 32'(A), 501 % 256);
      chk("s2_B", 32'(B), 501 / 256);
      check_stats("s2_partial", 501 - L);
      while (c < 65535) begin
         tick(1);
         c++;
      end
      chk("s2_last_A", 32'(A), 255);
      chk("s2_last_B", 32'(B), 255);
      start = 1'b1;
      while (!done && c < 65545) begin
         tick(1);
         c++;
      end
      start = 1'b0;
      chk("s2_done_cycle", c, 65536 + L);
      chk("s2_done", 32'(done), 1);
      chk("s2_busy_end", 32'(busy), 0);
      chk("s2_A_end", 32'(A), 0);
      check_stats("s2_final", 65536);
      tick(3);
      chk("s2_done_hold", 32'(done), 1);
      chk("s2_B_hold", 32'(B), 0);
      check_stats("s2_hold", 65536);

      // Restart from DONE clears statistics
      mode = 1;
      start_pulse();
      chk("s3_done", 32'(done), 0);
      chk("s3_busy", 32'(busy), 1);
      check_stats("s3_clear", 0);
      tick(2000);
      chk("s3_A", 32'(A), 2000 % 256);
      chk("s3_B", 32'(B), 2000 / 256);
      check_stats("s3_partial", 2000 - L);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
